// File: rtl/cpx_multiply_pkg.sv
// rtl/cpx_multiply_pkg.sv - shared widths and latency for the complex multiplier
package cpx_multiply_pkg;

    localparam int CPX_IN_BITS      = 12;
    localparam int CPX_OUT_BITS     = 24;
    localparam int CPX_MULT_LATENCY = 3;

    function automatic int cpx_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/cpx_multiply_mult.sv
// rtl/cpx_multiply_mult.sv - registered signed A x B multiplier with valid pass-through
module signed_mult_reg #(
    parameter int a_bits = 12,
    parameter int b_bits = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             a_tvalid,
    input  logic signed [a_bits-1:0]         a,
    input  logic signed [b_bits-1:0]         b,
    output logic                             p_tvalid,
    output logic signed [a_bits+b_bits-1:0]  p
);

    localparam int P_BITS = a_bits + b_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_tvalid <= 1'b0;
            p        <= '0;
        end else begin
            p_tvalid <= a_tvalid;
            // Product register only moves on a live sample so stale data stays put.
            if (a_tvalid) begin
                p <= P_BITS'(a) * P_BITS'(b);
            end
        end
    end

endmodule

// File: rtl/cpx_multiply.sv
// rtl/cpx_multiply.sv - three-stage pipelined signed complex multiplier
module cpx_multiply
    import cpx_multiply_pkg::*;
#(
    parameter int xi_bits = CPX_IN_BITS,
    parameter int xq_bits = CPX_IN_BITS,
    parameter int yi_bits = CPX_IN_BITS,
    parameter int yq_bits = CPX_IN_BITS,
    parameter int i_bits  = xi_bits + yi_bits,
    parameter int q_bits  = xq_bits + yq_bits
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       m_axis_x_tvalid,
    input  logic signed [xi_bits-1:0]  xi,
    input  logic signed [xq_bits-1:0]  xq,
    input  logic                       m_axis_y_tvalid,
    input  logic signed [yi_bits-1:0]  yi,
    input  logic signed [yq_bits-1:0]  yq,
    output logic signed [i_bits-1:0]   i,
    output logic                       s_axis_i_tvalid,
    output logic signed [q_bits-1:0]   q,
    output logic                       s_axis_q_tvalid
);

    localparam int P_II_BITS = xi_bits + yi_bits;
    localparam int P_QQ_BITS = xq_bits + yq_bits;
    localparam int P_IQ_BITS = xi_bits + yq_bits;
    localparam int P_QI_BITS = xq_bits + yi_bits;
    localparam int SUM_BITS  = cpx_max4(P_II_BITS, P_QQ_BITS, P_IQ_BITS, P_QI_BITS) + 1;

    // Stage 1: operand capture, only on a matched x/y handshake.
    logic                      accept;
    logic                      s1_valid;
    logic signed [xi_bits-1:0] xi_r;
    logic signed [xq_bits-1:0] xq_r;
    logic signed [yi_bits-1:0] yi_r;
    logic signed [yq_bits-1:0] yq_r;

    assign accept = m_axis_x_tvalid && m_axis_y_tvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            xi_r     <= '0;
            xq_r     <= '0;
            yi_r     <= '0;
            yq_r     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                xi_r <= xi;
                xq_r <= xq;
                yi_r <= yi;
                yq_r <= yq;
            end
        end
    end

    // Stage 2: four full-width partial products.
    logic                        v_ii, v_qq, v_iq, v_qi;
    logic signed [P_II_BITS-1:0] p_ii;
    logic signed [P_QQ_BITS-1:0] p_qq;
    logic signed [P_IQ_BITS-1:0] p_iq;
    logic signed [P_QI_BITS-1:0] p_qi;
    logic                        s2_valid;

    signed_mult_reg #(.a_bits(xi_bits), .b_bits(yi_bits)) u_mult_ii (
        .clk(clk), .rst(rst), .a_tvalid(s1_valid), .a(xi_r), .b(yi_r),
        .p_tvalid(v_ii), .p(p_ii)
    );

    signed_mult_reg #(.a_bits(xq_bits), .b_bits(yq_bits)) u_mult_qq (
        .clk(clk), .rst(rst), .a_tvalid(s1_valid), .a(xq_r), .b(yq_r),
        .p_tvalid(v_qq), .p(p_qq)
    );

    signed_mult_reg #(.a_bits(xi_bits), .b_bits(yq_bits)) u_mult_iq (
        .clk(clk), .rst(rst), .a_tvalid(s1_valid), .a(xi_r), .b(yq_r),
        .p_tvalid(v_iq), .p(p_iq)
    );

    signed_mult_reg #(.a_bits(xq_bits), .b_bits(yi_bits)) u_mult_qi (
        .clk(clk), .rst(rst), .a_tvalid(s1_valid), .a(xq_r), .b(yi_r),
        .p_tvalid(v_qi), .p(p_qi)
    );

    // All four valids are driven from the same source, so they always agree.
    assign s2_valid = v_ii & v_qq & v_iq & v_qi;

    // Stage 3: combine at one guard bit above the widest product, then wrap to output width.
    always_ff @(posedge clk) begin
        if (rst) begin
            i               <= '0;
            q               <= '0;
            s_axis_i_tvalid <= 1'b0;
            s_axis_q_tvalid <= 1'b0;
        end else begin
            s_axis_i_tvalid <= s2_valid;
            s_axis_q_tvalid <= s2_valid;
            if (s2_valid) begin
                i <= i_bits'(SUM_BITS'(p_ii) - SUM_BITS'(p_qq));
                q <= q_bits'(SUM_BITS'(p_iq) + SUM_BITS'(p_qi));
            end
        end
    end

endmodule

// File: tb/tb_cpx_multiply.sv
// tb/tb_cpx_multiply.sv - directed self-checking bench for cpx_multiply
module tb_cpx_multiply;

    logic                clk;
    logic                rst;
    logic                x_tvalid;
    logic                y_tvalid;
    logic signed [11:0]  xi, xq, yi, yq;
    logic signed [23:0]  i_o, q_o;
    logic                i_tvalid, q_tvalid;

    int checks;
    int failures;

    cpx_multiply dut (
        .clk            (clk),
        .rst            (rst),
        .m_axis_x_tvalid(x_tvalid),
        .xi             (xi),
        .xq             (xq),
        .m_axis_y_tvalid(y_tvalid),
        .yi             (yi),
        .yq             (yq),
        .i              (i_o),
        .s_axis_i_tvalid(i_tvalid),
        .q              (q_o),
        .s_axis_q_tvalid(q_tvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, take one rising edge, then settle 1 time unit before sampling.
    task automatic step(input logic xv, input logic yv,
                        input int a_i, input int a_q, input int b_i, input int b_q);
        x_tvalid = xv;
        y_tvalid = yv;
        xi = 12'(a_i);
        xq = 12'(a_q);
        yi = 12'(b_i);
        yq = 12'(b_q);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string tag, input logic v_exp, input int ie, input int qe);
        logic signed [23:0] i_exp;
        logic signed [23:0] q_exp;
        i_exp = 24'(ie);
        q_exp = 24'(qe);
        checks++;
        assert (i_tvalid === v_exp) else begin
            failures++;
            $error("FAIL %s i_tvalid observed=%0b expected=%0b", tag, i_tvalid, v_exp);
        end
        checks++;
        assert (q_tvalid === v_exp) else begin
            failures++;
            $error("FAIL %s q_tvalid observed=%0b expected=%0b", tag, q_tvalid, v_exp);
        end
        checks++;
        assert (i_o === i_exp) else begin
            failures++;
            $error("FAIL %s i observed=%0d expected=%0d", tag, i_o, i_exp);
        end
        checks++;
        assert (q_o === q_exp) else begin
            failures++;
            $error("FAIL %s q observed=%0d expected=%0d", tag, q_o, q_exp);
        end
    endtask

    // One isolated sample: output appears on the third edge counting the capture edge, then holds.
    task automatic single(input string tag, input int a_i, input int a_q,
                          input int b_i, input int b_q, input int ie, input int qe);
        step(1'b1, 1'b1, a_i, a_q, b_i, b_q);
        chk({tag, "_lat1"}, 1'b0, prev_i, prev_q);
        idle();
        chk({tag, "_lat2"}, 1'b0, prev_i, prev_q);
        idle();
        chk(tag, 1'b1, ie, qe);
        idle();
        chk({tag, "_hold"}, 1'b0, ie, qe);
        prev_i = ie;
        prev_q = qe;
    endtask

    int prev_i;
    int prev_q;

    initial begin
        checks   = 0;
        failures = 0;
        prev_i   = 0;
        prev_q   = 0;
        rst      = 1'b1;
        idle();
        idle();
        chk("reset", 1'b0, 0, 0);
        rst = 1'b0;
        idle();
        chk("post_reset", 1'b0, 0, 0);

        single("basic",     3,     4,     1,     2,    -5,       10);
        single("conj",      1,     1,     1,    -1,     2,        0);
        single("sign",     -7,     0,     0,     5,     0,      -35);
        single("wrap",  -2048, -2048, -2048, -2048,     0, -8388608);
        single("nowrap", -2048, -2048, -2048,  2047, 8386560,   2048);

        // Stream of five with one x-only cycle in the middle.
        step(1'b1, 1'b1,   2,   0,    5,   0);
        step(1'b1, 1'b1,   0,   1,    0,   1);
        step(1'b1, 1'b0, 100, 100,  100, 100);
        chk("strm_s1", 1'b1, 10, 0);
        step(1'b1, 1'b1,   1,   1,    2,   3);
        chk("strm_s2", 1'b1, -1, 0);
        step(1'b1, 1'b1,  -3,   2,    4,  -1);
        chk("strm_gap", 1'b0, -1, 0);
        step(1'b1, 1'b1, 2047,  0, 2047,   0);
        chk("strm_s3", 1'b1, -1, 5);
        step(1'b0, 1'b1, 50, 50, 50, 50);
        chk("strm_s4", 1'b1, -10, 11);
        idle();
        chk("strm_s5", 1'b1, 4190209, 0);
        idle();
        chk("strm_tail", 1'b0, 4190209, 0);
        idle();
        chk("strm_yonly", 1'b0, 4190209, 0);

        // Reset with two samples in flight.
        step(1'b1, 1'b1, 3, 4, 1, 2);
        step(1'b1, 1'b1, 1, 1, 1, -1);
        rst = 1'b1;
        idle();
        chk("flush_rst", 1'b0, 0, 0);
        rst = 1'b0;
        idle();
        chk("flush_1", 1'b0, 0, 0);
        idle();
        chk("flush_2", 1'b0, 0, 0);
        idle();
        chk("flush_3", 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
